// File: rtl/t_meas_pkg.sv
// Shared types and defaults for the T flip-flop period meter.
package t_meas_pkg;

    localparam int unsigned CNT_W_DEF = 16;

    typedef enum logic {
        IDLE = 1'b0,
        MEAS = 1'b1
    } meas_state_t;

endpackage

// File: rtl/t_edge_det.sv
// Samples the measured Q signal and produces registered level/rise/fall strobes.
// Define T_PERIOD_METER_SYNC_EN to put a 2-flop synchronizer in front of q_s.
module t_edge_det (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_q,
    output logic o_rise,
    output logic o_fall,
    output logic o_level
);

    logic q_in;
    logic q_s;
    logic q_d;

`ifdef T_PERIOD_METER_SYNC_EN
    logic sync_m;

    // q_s is the second flop of the synchronizer, so only one extra cycle is added
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_m <= 1'b0;
        end else begin
            sync_m <= i_q;
        end
    end

    assign q_in = sync_m;
`else
    assign q_in = i_q;
`endif

    // Strobes are registered; o_level stays phase-aligned with o_rise/o_fall
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            q_s     <= 1'b0;
            q_d     <= 1'b0;
            o_rise  <= 1'b0;
            o_fall  <= 1'b0;
            o_level <= 1'b0;
        end else begin
            q_s     <= q_in;
            q_d     <= q_s;
            o_rise  <= q_s & ~q_d;
            o_fall  <= ~q_s & q_d;
            o_level <= q_s;
        end
    end

endmodule

// File: rtl/t_period_meter.sv
// Measures period and high time of a toggle-flop output with a valid/ready result port.
// Define T_PERIOD_METER_SYNC_EN when i_q is asynchronous to i_clk.
module t_period_meter
    import t_meas_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_q,
    input  logic             i_ready,
    output logic [CNT_W-1:0] o_period,
    output logic [CNT_W-1:0] o_high,
    output logic             o_valid,
    output logic             o_overrun,
    output logic             o_timeout
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    meas_state_t      state_q;
    meas_state_t      state_d;
    logic             rise;
    logic             fall;
    logic             level;
    logic             do_load;
    logic             do_cap;
    logic             do_tmo;
    logic             xfer;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] h_stg;

    t_edge_det u_edge_det (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_q     (i_q),
        .o_rise  (rise),
        .o_fall  (fall),
        .o_level (level)
    );

    assign xfer = o_valid & i_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        do_load = 1'b0;
        do_cap  = 1'b0;
        do_tmo  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = MEAS;
                    do_load = 1'b1;
                end
            end
            MEAS: begin
                if (rise) begin
                    do_cap  = 1'b1;
                    do_load = 1'b1;
                end else if (cnt == CNT_MAX) begin
                    state_d = IDLE;
                    do_tmo  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // hcnt only advances alongside cnt, so it can never pass it
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt   <= '0;
            hcnt  <= '0;
            h_stg <= '0;
        end else begin
            if (do_load) begin
                cnt  <= CNT_W'(1);
                hcnt <= CNT_W'(1);
            end else if (state_q == MEAS && !do_tmo) begin
                cnt  <= cnt + CNT_W'(1);
                hcnt <= hcnt + CNT_W'(level);
            end
            if (do_load) begin
                h_stg <= '0;
            end else if (state_q == MEAS && fall) begin
                h_stg <= hcnt;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_period  <= '0;
            o_high    <= '0;
            o_valid   <= 1'b0;
            o_overrun <= 1'b0;
            o_timeout <= 1'b0;
        end else begin
            o_timeout <= do_tmo;
            if (do_cap) begin
                o_period <= cnt;
                o_high   <= h_stg;
                o_valid  <= 1'b1;
                if (o_valid && !i_ready) begin
                    o_overrun <= 1'b1;
                end
            end else if (xfer) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_t_period_meter.sv
// Directed bench for t_period_meter: a default-width instance and a CNT_W=4 instance.
module tb_t_period_meter;

`ifdef T_PERIOD_METER_SYNC_EN
    localparam int LATD = 3;
`else
    localparam int LATD = 2;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        q;
    logic        rdy;
    logic [15:0] p16, h16;
    logic        v16, ov16, to16;
    logic [3:0]  p4, h4;
    logic        v4, ov4, to4;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    t_period_meter #(.CNT_W(16)) dut16 (
        .i_clk(clk), .i_rst(rst), .i_q(q), .i_ready(rdy),
        .o_period(p16), .o_high(h16), .o_valid(v16), .o_overrun(ov16), .o_timeout(to16)
    );

    t_period_meter #(.CNT_W(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_q(q), .i_ready(rdy),
        .o_period(p4), .o_high(h4), .o_valid(v4), .o_overrun(ov4), .o_timeout(to4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        q   = 1'b0;
        rdy = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        q   = 1'b1;
        rdy = 1'b0;
        tick();
        tick();
        total++;
        if ({v16, ov16, to16, p16, h16} !== 35'd0) begin
            bad++;
            $display("FAIL reset16: got v=%b ov=%b to=%b p=%0d h=%0d want all 0", v16, ov16, to16, p16, h16);
        end
        total++;
        if ({v4, ov4, to4, p4, h4} !== 11'd0) begin
            bad++;
            $display("FAIL reset4: got v=%b ov=%b to=%b p=%0d h=%0d want all 0", v4, ov4, to4, p4, h4);
        end
        rst = 1'b0;
        q   = 1'b0;
    endtask

    task automatic test_square();
        logic exp_v;
        apply_reset();
        rdy = 1'b1;
        for (int i = 0; i < 44; i++) begin
            q = ((i % 8) < 4);
            tick();
            exp_v = (i >= 8 + LATD) && (((i - LATD) % 8) == 0);
            total++;
            if (v16 !== exp_v) begin
                bad++;
                $display("FAIL square_valid i=%0d: got %b want %b", i, v16, exp_v);
            end
            if (exp_v) begin
                total++;
                if (p16 !== 16'd8 || h16 !== 16'd4) begin
                    bad++;
                    $display("FAIL square_data i=%0d: got p=%0d h=%0d want p=8 h=4", i, p16, h16);
                end
            end
        end
    endtask

    task automatic test_overrun();
        apply_reset();
        rdy = 1'b0;
        for (int i = 0; i < 30; i++) begin
            q = ((i % 10) < 3);
            tick();
            if (i == 15) begin
                total++;
                if (v16 !== 1'b1 || ov16 !== 1'b0 || p16 !== 16'd10 || h16 !== 16'd3) begin
                    bad++;
                    $display("FAIL overrun_first: got v=%b ov=%b p=%0d h=%0d want v=1 ov=0 p=10 h=3", v16, ov16, p16, h16);
                end
            end
        end
        total++;
        if (v16 !== 1'b1 || ov16 !== 1'b1 || p16 !== 16'd10 || h16 !== 16'd3) begin
            bad++;
            $display("FAIL overrun_second: got v=%b ov=%b p=%0d h=%0d want v=1 ov=1 p=10 h=3", v16, ov16, p16, h16);
        end
        q   = 1'b0;
        rdy = 1'b1;
        tick();
        total++;
        if (v16 !== 1'b0 || ov16 !== 1'b1) begin
            bad++;
            $display("FAIL overrun_drain: got v=%b ov=%b want v=0 ov=1", v16, ov16);
        end
        tick();
        total++;
        if (ov16 !== 1'b1) begin
            bad++;
            $display("FAIL overrun_sticky: got %b want 1", ov16);
        end
    endtask

    task automatic test_timeout();
        logic exp_v;
        apply_reset();
        rdy = 1'b1;
        for (int i = 0; i < 22; i++) begin
            q = (i == 0);
            tick();
            total++;
            if (to4 !== (i == LATD + 15) || v4 !== 1'b0) begin
                bad++;
                $display("FAIL timeout_pulse i=%0d: got to=%b v=%b want to=%b v=0", i, to4, v4, (i == LATD + 15));
            end
        end
        for (int i = 22; i < 28 + LATD + 3; i++) begin
            q = (i == 22) || (i == 23) || (i == 28) || (i == 29);
            tick();
            exp_v = (i == 28 + LATD);
            total++;
            if (v4 !== exp_v) begin
                bad++;
                $display("FAIL timeout_recover_valid i=%0d: got %b want %b", i, v4, exp_v);
            end
            if (exp_v) begin
                total++;
                if (p4 !== 4'd6 || h4 !== 4'd2) begin
                    bad++;
                    $display("FAIL timeout_recover_data: got p=%0d h=%0d want p=6 h=2", p4, h4);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int nres;
        apply_reset();
        rdy = 1'b0;
        for (int i = 0; i < 13 + LATD; i++) begin
            q = ((i % 8) < 4);
            tick();
            if (i == 12 + LATD) begin
                total++;
                if (v16 !== 1'b1 || p16 !== 16'd8) begin
                    bad++;
                    $display("FAIL midrst_pre: got v=%b p=%0d want v=1 p=8", v16, p16);
                end
            end
        end
        rst = 1'b1;
        q   = 1'b0;
        tick();
        total++;
        if ({v16, ov16, to16, p16, h16} !== 35'd0) begin
            bad++;
            $display("FAIL midrst_clear: got v=%b ov=%b to=%b p=%0d h=%0d want all 0", v16, ov16, to16, p16, h16);
        end
        rst  = 1'b0;
        rdy  = 1'b1;
        nres = 0;
        for (int i = 0; i < 30; i++) begin
            q = (i >= 4 && i < 7) || (i >= 10 && i < 13);
            tick();
            if (v16) begin
                nres++;
                total++;
                if (p16 !== 16'd6 || h16 !== 16'd3) begin
                    bad++;
                    $display("FAIL midrst_data: got p=%0d h=%0d want p=6 h=3", p16, h16);
                end
            end
        end
        total++;
        if (nres !== 1) begin
            bad++;
            $display("FAIL midrst_count: got %0d results want 1", nres);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int i = 0; i < 19 + LATD; i++) begin
            q   = (i < 4) || (i >= 8 && i < 13) || (i >= 18 && i < 23);
            rdy = (i == 18 + LATD);
            tick();
            if (i == 17 + LATD) begin
                total++;
                if (v16 !== 1'b1 || p16 !== 16'd8 || h16 !== 16'd4 || ov16 !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_hold: got v=%b p=%0d h=%0d ov=%b want v=1 p=8 h=4 ov=0", v16, p16, h16, ov16);
                end
            end
            if (i == 18 + LATD) begin
                total++;
                if (v16 !== 1'b1 || p16 !== 16'd10 || h16 !== 16'd5 || ov16 !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_load: got v=%b p=%0d h=%0d ov=%b want v=1 p=10 h=5 ov=0", v16, p16, h16, ov16);
                end
            end
        end
        q   = 1'b0;
        rdy = 1'b1;
        tick();
        total++;
        if (v16 !== 1'b0 || ov16 !== 1'b0) begin
            bad++;
            $display("FAIL b2b_drain: got v=%b ov=%b want v=0 ov=0", v16, ov16);
        end
    endtask

    initial begin
        rst = 1'b1;
        q   = 1'b0;
        rdy = 1'b0;
        test_reset();
        test_square();
        test_overrun();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/t_period_meter.md
T_PERIOD_METER -- requirements
Module: t_period_meter

Interface
REQ-001 Parameter CNT_W, default 16, SHALL set the width of the period and high-time counters and outputs; the legal range is 4..32.
REQ-002 i_clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 i_rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 i_q  input  1  SHALL be the toggle-flop output (Q) being measured; it is asynchronous to i_clk when T_PERIOD_METER_SYNC_EN is defined.
REQ-005 i_ready  input  1  SHALL be the consumer ready signal; a result transfers in any cycle where o_valid and i_ready are both 1.
REQ-006 o_period  output  CNT_W  SHALL be the clock cycles between two consecutive rising edges of i_q.
REQ-007 o_high  output  CNT_W  SHALL be the clock cycles i_q was high within that period.
REQ-008 o_valid  output  1  SHALL mark o_period and o_high as holding an untransferred result.
REQ-009 o_overrun  output  1  SHALL be a sticky flag: a result was overwritten before it transferred.
REQ-010 o_timeout  output  1  SHALL be a one-cycle pulse: the period counter saturated with no rising edge.

Function
REQ-011 q_s SHALL be the registered sample of i_q, and q_d SHALL be q_s delayed by one cycle.
REQ-012 rise SHALL equal q_s & ~q_d, and fall SHALL equal ~q_s & q_d.
REQ-013 The FSM SHALL have two states: IDLE (no reference edge yet) and MEAS (counting).
REQ-014 In IDLE on rise, the FSM SHALL go to MEAS, load cnt=1 and hcnt=1, and produce no result.
REQ-015 In MEAS on a cycle without rise, cnt SHALL increment by 1, and hcnt SHALL increment by 1 while q_s=1 and hold otherwise.
REQ-016 In MEAS on fall, hcnt SHALL be copied into a staging register h_stg.
REQ-017 In MEAS on rise, cnt SHALL be captured into o_period and h_stg into o_high, o_valid SHALL be set to 1, cnt and hcnt SHALL reload to 1, and h_stg SHALL clear to 0.
REQ-018 Capture latency SHALL be: i_q rising before clock edge k gives o_valid=1 after edge k+2 (the synchronizer macro adds 1).
REQ-019 In MEAS, when cnt reaches 2^CNT_W-1 with no rise, the FSM SHALL go to IDLE, pulse o_timeout for 1 cycle, and leave o_valid and its data unchanged.
REQ-020 o_valid SHALL stay 1, with o_period and o_high stable, until transfer; on transfer with no simultaneous capture, o_valid SHALL clear.
REQ-021 On capture while o_valid=1 and i_ready=0, the data SHALL be overwritten, o_valid SHALL stay 1, and o_overrun SHALL set.
REQ-022 On capture and transfer in the same cycle, the new data SHALL load, o_valid SHALL stay 1, and o_overrun SHALL be unchanged.
REQ-023 hcnt SHALL never exceed cnt; if i_q stays constantly high it SHALL end in timeout per REQ-019.

Reset
REQ-024 When i_rst=1 at a clock edge: FSM=IDLE; cnt, hcnt, h_stg, o_period, o_high = 0; o_valid, o_overrun, o_timeout = 0; q_s, q_d and any synchronizer stages = 0.
REQ-025 Reset mid-measurement SHALL discard the partial count, and the first rise after reset SHALL produce no result.

Configuration
REQ-026 With T_PERIOD_METER_SYNC_EN defined, i_q SHALL pass through a 2-flop synchronizer before q_s, adding exactly 1 cycle of latency.
REQ-027 Without T_PERIOD_METER_SYNC_EN, i_q SHALL be registered once into q_s; i_q must then be synchronous to i_clk.

Structure
REQ-028 Package t_meas_pkg SHALL hold the FSM state typedef (IDLE, MEAS) and the constant CNT_W_DEF=16.
REQ-029 Sub-module t_edge_det SHALL contain the optional synchronizer, q_s/q_d and rise/fall generation; t_period_meter SHALL contain the FSM, counters and output handshake.

Verification
REQ-030 i_q square wave, period 8 cycles, high 4, i_ready=1 -> first rise gives no result; every later rise gives o_period=8, o_high=4, o_valid high 1 cycle.
REQ-031 Period 10, high 3, i_ready=0 for 2 captures -> o_valid stays 1, o_overrun=1, o_period=10, o_high=3; i_ready=1 -> o_valid clears, o_overrun stays 1.
REQ-032 CNT_W=4, one rise then i_q low for 20 cycles -> o_timeout pulses 15 cycles after the rise, o_valid=0; the next rise gives no result, the following rise a valid period.
REQ-033 i_rst=1 for 1 cycle mid-period (cnt=5, o_valid=1) -> all outputs 0 next cycle; the next two rises 6 cycles apart give exactly one result, o_period=6.
REQ-034 Capture coinciding with o_valid&i_ready -> new data visible next cycle, o_valid=1, o_overrun=0.
REQ-035 Rerun REQ-030 with and without T_PERIOD_METER_SYNC_EN -> identical values; o_valid is exactly 1 cycle later with the macro.
